// File: rtl/multi_cycle_execute_stage4.sv
// ---------------------------------------------------------------------------
// multi_cycle_execute_stage4
//
// Fourth stage of the floating-point multi-cycle pipeline, between mx3
// (alignment, add/subtract, significand extraction) and mx5 (normalization
// shift, rounding, result select).
//
// For every lane, this stage does two things:
//   * It counts the leading zeros of the 32-bit add/subtract significand.
//     mx5 uses this count as the normalization shift.
//   * It forms the full unsigned 24x24 -> 48-bit significand product.
// Both results are registered with all sideband and control signals. The
// latency is fixed at one cycle. There is no stall and no back-pressure.
//
// Ports:
//   clk                      pipeline clock
//   reset                    asynchronous reset, active low
//   mx3_instruction_valid    stage-3 slot holds a live instruction
//   mx3_instruction          decoded instruction
//   mx3_mask_value           lane write mask (not used to gate compute)
//   mx3_thread_idx           issuing thread
//   mx3_subcycle             subcycle number
//   mx3_result_is_inf/nan    per-lane special-case flags (passed through)
//   mx3_add_significand      per-lane unnormalized sum / ftoi integer
//   mx3_add_exponent         per-lane pre-normalization add exponent
//   mx3_add_result_sign      per-lane sign of sum
//   mx3_logical_subtract     per-lane effective subtraction flag
//   mx3_significand1/2       per-lane 24-bit significands incl. hidden bit
//   mx3_mul_exponent         per-lane biased product exponent
//   mx3_mul_sign             per-lane product sign
//   mx4_*                    registered copies of the above, plus:
//   mx4_norm_shift           per-lane leading-zero count (0..32)
//   mx4_significand_product  per-lane 48-bit significand product
// ---------------------------------------------------------------------------

`ifndef VECTOR_LANES
`define VECTOR_LANES 16
`endif

package multi_cycle_execute_stage4_pkg;

  typedef logic [1:0] thread_idx_t;
  typedef logic [3:0] subcycle_t;

  // Decoded instruction word. This stage only carries it through; mx5 and
  // writeback interpret the fields.
  typedef struct packed {
    logic [5:0] alu_op;
    logic       has_dest;
    logic       dest_is_vector;
    logic [4:0] dest_reg;
    logic [4:0] scalar_sel1;
    logic [4:0] scalar_sel2;
    logic [1:0] mask_src;
    logic       compare;
    subcycle_t  last_subcycle;
    logic       cache_control;
    logic       pipeline_sel;
  } decoded_instruction_t;

endpackage

module multi_cycle_execute_stage4
  import multi_cycle_execute_stage4_pkg::*;
#(
  parameter int NUM_LANES = `VECTOR_LANES
) (
  input  logic                             clk,
  input  logic                             reset,

  input  logic                             mx3_instruction_valid,
  input  decoded_instruction_t             mx3_instruction,
  input  logic [NUM_LANES-1:0]             mx3_mask_value,
  input  thread_idx_t                      mx3_thread_idx,
  input  subcycle_t                        mx3_subcycle,
  input  logic [NUM_LANES-1:0]             mx3_result_is_inf,
  input  logic [NUM_LANES-1:0]             mx3_result_is_nan,
  input  logic [NUM_LANES-1:0][31:0]       mx3_add_significand,
  input  logic [NUM_LANES-1:0][7:0]        mx3_add_exponent,
  input  logic [NUM_LANES-1:0]             mx3_add_result_sign,
  input  logic [NUM_LANES-1:0]             mx3_logical_subtract,
  input  logic [NUM_LANES-1:0][23:0]       mx3_significand1,
  input  logic [NUM_LANES-1:0][23:0]       mx3_significand2,
  input  logic [NUM_LANES-1:0][7:0]        mx3_mul_exponent,
  input  logic [NUM_LANES-1:0]             mx3_mul_sign,

  output logic                             mx4_instruction_valid,
  output decoded_instruction_t             mx4_instruction,
  output logic [NUM_LANES-1:0]             mx4_mask_value,
  output thread_idx_t                      mx4_thread_idx,
  output subcycle_t                        mx4_subcycle,
  output logic [NUM_LANES-1:0]             mx4_result_is_inf,
  output logic [NUM_LANES-1:0]             mx4_result_is_nan,
  output logic [NUM_LANES-1:0][31:0]       mx4_add_significand,
  output logic [NUM_LANES-1:0][7:0]        mx4_add_exponent,
  output logic [NUM_LANES-1:0]             mx4_add_result_sign,
  output logic [NUM_LANES-1:0]             mx4_logical_subtract,
  output logic [NUM_LANES-1:0][5:0]        mx4_norm_shift,
  output logic [NUM_LANES-1:0][47:0]       mx4_significand_product,
  output logic [NUM_LANES-1:0][7:0]        mx4_mul_exponent,
  output logic [NUM_LANES-1:0]             mx4_mul_sign
);

  // Leading zeros in a 4-bit group. Returns 4 when the group is all zero.
  function automatic logic [2:0] nibble_lz(input logic [3:0] n);
    logic [2:0] lz;
    casez (n)
      4'b1???: lz = 3'd0;
      4'b01??: lz = 3'd1;
      4'b001?: lz = 3'd2;
      4'b0001: lz = 3'd3;
      default: lz = 3'd4;
    endcase
    return lz;
  endfunction

  // Two-level leading-zero count. The first nonzero nibble, scanning from
  // the MSB, selects a coarse offset of 4 * (number of zero nibbles above
  // it). The nibble's own count is added to that offset. An all-zero word
  // falls through to 32, so a 6-bit result is needed.
  function automatic logic [5:0] count_leading_zeros(input logic [31:0] v);
    logic [5:0] count;
    logic       found;
    count = 6'd32;
    found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!found && (v[i*4 +: 4] != 4'd0)) begin
        count = 6'((7 - i) * 4) + {3'b000, nibble_lz(v[i*4 +: 4])};
        found = 1'b1;
      end
    end
    return count;
  endfunction

  logic [NUM_LANES-1:0][5:0]  norm_shift_next;
  logic [NUM_LANES-1:0][47:0] product_next;

  // Per-lane datapath. Lanes share nothing. The mask and alu_op never gate
  // the arithmetic; mx5 and writeback decide what to keep.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      always_comb begin
        norm_shift_next[gi] = count_leading_zeros(mx3_add_significand[gi]);
      end

      // Zero-extend both operands to 48 bits so the product is not
      // truncated.
      always_comb begin
        product_next[gi] = {24'd0, mx3_significand1[gi]} *
                           {24'd0, mx3_significand2[gi]};
      end
    end
  endgenerate

  // Pipeline register. Reset clears every output, including the datapath
  // outputs. Without reset, everything loads every cycle, even on bubbles;
  // only the valid bit tells the consumer whether the data means anything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mx4_instruction_valid   <= 1'b0;
      mx4_instruction         <= '0;
      mx4_mask_value          <= '0;
      mx4_thread_idx          <= '0;
      mx4_subcycle            <= '0;
      mx4_result_is_inf       <= '0;
      mx4_result_is_nan       <= '0;
      mx4_add_significand     <= '0;
      mx4_add_exponent        <= '0;
      mx4_add_result_sign     <= '0;
      mx4_logical_subtract    <= '0;
      mx4_norm_shift          <= '0;
      mx4_significand_product <= '0;
      mx4_mul_exponent        <= '0;
      mx4_mul_sign            <= '0;
    end else begin
      mx4_instruction_valid   <= mx3_instruction_valid;
      mx4_instruction         <= mx3_instruction;
      mx4_mask_value          <= mx3_mask_value;
      mx4_thread_idx          <= mx3_thread_idx;
      mx4_subcycle            <= mx3_subcycle;
      mx4_result_is_inf       <= mx3_result_is_inf;
      mx4_result_is_nan       <= mx3_result_is_nan;
      mx4_add_significand     <= mx3_add_significand;
      mx4_add_exponent        <= mx3_add_exponent;
      mx4_add_result_sign     <= mx3_add_result_sign;
      mx4_logical_subtract    <= mx3_logical_subtract;
      mx4_norm_shift          <= norm_shift_next;
      mx4_significand_product <= product_next;
      mx4_mul_exponent        <= mx3_mul_exponent;
      mx4_mul_sign            <= mx3_mul_sign;
    end
  end

endmodule
